// File: rtl/trace_issue_buffer_pkg.sv
// Shared types and constants for the trace issue buffer and its entry FIFO.
// Also holds the entry/output structs the trace front end already uses.
package trace_issue_buffer_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int TIME_WIDTH    = 32;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FETCH = 2'd2
  } parsed_op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TIME = 2'd1,
    ISSUE     = 2'd2,
    STALL     = 2'd3
  } issue_states_t;

  typedef struct packed {
    logic [TIME_WIDTH-1:0]    time_cpu;
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
  } trace_entry_t;

  typedef struct packed {
    logic                     op_ready_s;
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [TIME_WIDTH-1:0]    time_cpu;
  } parser_out_struct_t;

endpackage

// File: rtl/trace_entry_fifo.sv
// Circular storage for trace entries: pointers, occupancy, full/empty.
// Exposes the head and the time of the entry behind it for back-to-back issue.
import trace_issue_buffer_pkg::*;

module trace_entry_fifo #(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  trace_entry_t          wdata_i,
  input  logic                  pop_i,
  output trace_entry_t          head_o,
  output logic [TIME_WIDTH-1:0] head_next_time_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  trace_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   cnt_q;
  logic            push_ok, pop_ok;
  trace_entry_t    next_e;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign next_e  = mem_q[rd_q + PW'(1)];
  assign head_next_time_o = next_e.time_cpu;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop_ok)  rd_q <= rd_q + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/trace_issue_buffer.sv
// Buffers parsed trace entries and issues the head once cur_time is due.
// Optional TRACE_TIME_SKIP_EN exposes the head timestamp while waiting.
import trace_issue_buffer_pkg::*;

module trace_issue_buffer #(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int TIME_W = TIME_WIDTH,
  parameter int ADDR_W = ADDRESS_WIDTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TIME_W-1:0]  in_time,
  input  logic [1:0]         in_opcode,
  input  logic [ADDR_W-1:0]  in_address,
  input  logic [TIME_W-1:0]  cur_time,
  input  logic               queue_full,
  output parser_out_struct_t out,
  output logic [CW-1:0]      count,
  output logic               err_order,
  output logic               err_opcode,
  output issue_states_t      state
`ifdef TRACE_TIME_SKIP_EN
  ,
  output logic [TIME_W-1:0]  next_time,
  output logic               next_time_valid
`endif
);

  issue_states_t         state_q, state_d;
  logic [TIME_W-1:0]     last_time_q;
  logic                  err_order_q, err_opcode_q;
  logic                  push_acc, op_bad, wr_en, late, pop;
  logic [TIME_W-1:0]     wr_time;
  trace_entry_t          wr_entry, head;
  logic [TIME_WIDTH-1:0] next_t;
  logic                  full, empty, due_h, due_n;

  assign push_acc = in_valid && in_ready;
  assign op_bad   = (in_opcode == 2'd3);
  assign wr_en    = push_acc && !op_bad;
  assign late     = (in_time < last_time_q);
  assign wr_time  = late ? last_time_q : in_time;
  assign pop      = (state_q == ISSUE) && !queue_full;

  always_comb begin
    wr_entry          = '0;
    wr_entry.time_cpu = TIME_WIDTH'(wr_time);
    wr_entry.opcode   = parsed_op_t'(in_opcode);
    wr_entry.address  = ADDRESS_WIDTH'(in_address);
  end

  trace_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_i           (wr_en),
    .wdata_i          (wr_entry),
    .pop_i            (pop),
    .head_o           (head),
    .head_next_time_o (next_t),
    .count_o          (count),
    .full_o           (full),
    .empty_o          (empty)
  );

  assign in_ready = !full;
  assign due_h    = (cur_time >= TIME_W'(head.time_cpu));
  assign due_n    = (cur_time >= TIME_W'(next_t));

  // After a pop the next state is judged on the entry behind the head.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = WAIT_TIME;
      end
      WAIT_TIME: begin
        if (due_h) state_d = queue_full ? STALL : ISSUE;
      end
      ISSUE: begin
        if (!queue_full) begin
          if (count == CW'(1)) state_d = IDLE;
          else if (due_n)      state_d = ISSUE;
          else                 state_d = WAIT_TIME;
        end
      end
      STALL: begin
        if (!queue_full) state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_time_q  <= '0;
      err_order_q  <= 1'b0;
      err_opcode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en) last_time_q <= wr_time;
      if (wr_en && late) err_order_q <= 1'b1;
      if (push_acc && op_bad) err_opcode_q <= 1'b1;
    end
  end

  always_comb begin
    out            = '0;
    out.op_ready_s = (state_q == ISSUE);
    if (state_q != IDLE) begin
      out.opcode   = head.opcode;
      out.address  = head.address;
      out.time_cpu = head.time_cpu;
    end
  end

  assign err_order  = err_order_q;
  assign err_opcode = err_opcode_q;
  assign state      = state_q;

`ifdef TRACE_TIME_SKIP_EN
  assign next_time_valid = (state_q == WAIT_TIME);
  assign next_time = next_time_valid ? TIME_W'(head.time_cpu) : '0;
`endif

endmodule

// File: tb/tb_trace_issue_buffer.sv
// Directed bench for trace_issue_buffer: ordering, fill/stall, wrap,
// error flags, async reset and (with TRACE_TIME_SKIP_EN) time skip.
import trace_issue_buffer_pkg::*;

module tb_trace_issue_buffer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_time;
  logic [1:0]         in_opcode;
  logic [31:0]        in_address;
  logic [31:0]        cur_time;
  logic               queue_full;
  parser_out_struct_t out;
  logic [3:0]         count;
  logic               err_order;
  logic               err_opcode;
  issue_states_t      state;
`ifdef TRACE_TIME_SKIP_EN
  logic [31:0]        next_time;
  logic               next_time_valid;
`endif

  int checks = 0;
  int errors = 0;

  trace_issue_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_time    (in_time),
    .in_opcode  (in_opcode),
    .in_address (in_address),
    .cur_time   (cur_time),
    .queue_full (queue_full),
    .out        (out),
    .count      (count),
    .err_order  (err_order),
    .err_opcode (err_opcode),
    .state      (state)
`ifdef TRACE_TIME_SKIP_EN
    ,
    .next_time       (next_time),
    .next_time_valid (next_time_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] t, input logic [1:0] op,
                      input logic [31:0] a);
    in_valid   = 1'b1;
    in_time    = t;
    in_opcode  = op;
    in_address = a;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    queue_full = 1'b0;
    cur_time   = '0;
    in_time    = '0;
    in_opcode  = '0;
    in_address = '0;
    #4 rst_n = 1'b1;
  endtask

  initial begin
    int ni;
    int np;
    logic acc;
    logic [31:0] ea;
    logic [31:0] et;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_time    = '0;
    in_opcode  = '0;
    in_address = '0;
    cur_time   = '0;
    queue_full = 1'b0;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out.op_ready_s), 64'd0);
    chk("rst_addr", 64'(out.address), 64'd0);
    chk("rst_state", 64'(state), 64'(IDLE));
    chk("rst_errs", 64'({err_order, err_opcode}), 64'd0);
    rst_n = 1'b1;
    step();

    // two entries issued as time ramps
    push(32'd5, 2'd0, 32'h100);
    chk("t1_cnt1", 64'(count), 64'd1);
    push(32'd10, 2'd1, 32'h200);
    chk("t1_cnt2", 64'(count), 64'd2);
    chk("t1_wait", 64'(state), 64'(WAIT_TIME));
    ni = 0;
    for (int c = 0; c < 15; c++) begin
      cur_time = 32'(c);
      step();
      if (c == 8) chk("t1_mid_cnt", 64'(count), 64'd1);
      if (out.op_ready_s) begin
        ea = (ni == 0) ? 32'h100 : 32'h200;
        et = (ni == 0) ? 32'd5 : 32'd10;
        chk("t1_addr", 64'(out.address), 64'(ea));
        chk("t1_when", 64'(c), 64'(et));
        chk("t1_tcpu", 64'(out.time_cpu), 64'(et));
        ni++;
      end
    end
    chk("t1_issues", 64'(ni), 64'd2);
    chk("t1_cnt0", 64'(count), 64'd0);
    chk("t1_idle", 64'(state), 64'(IDLE));

    // fill with queue_full, then drain on consecutive cycles
    pulse_reset();
    queue_full = 1'b1;
    for (int i = 0; i < 8; i++) push(32'd0, 2'd0, 32'h1000 + 32'(i));
    in_valid   = 1'b1;
    in_address = 32'h1008;
    chk("t2_notready", 64'(in_ready), 64'd0);
    step();
    chk("t2_full_cnt", 64'(count), 64'd8);
    chk("t2_stall", 64'(state), 64'(STALL));
    in_valid   = 1'b0;
    queue_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_valid", 64'(out.op_ready_s), 64'd1);
      chk("t2_addr", 64'(out.address), 64'h1000 + 64'(i));
    end
    step();
    chk("t2_done_valid", 64'(out.op_ready_s), 64'd0);
    chk("t2_done_cnt", 64'(count), 64'd0);
    chk("t2_done_idle", 64'(state), 64'(IDLE));

    // streaming across three wraps
    pulse_reset();
    np = 0;
    ni = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid   = (np < 24);
      in_time    = '0;
      in_opcode  = 2'd2;
      in_address = 32'h2000 + 32'(np);
      acc = in_valid && in_ready;
      step();
      if (acc) np++;
      if (acc && c >= 2) chk("t3_cnt", 64'(count), 64'd3);
      if (out.op_ready_s) begin
        chk("t3_order", 64'(out.address), 64'h2000 + 64'(ni));
        ni++;
      end
    end
    in_valid = 1'b0;
    chk("t3_issued", 64'(ni), 64'd24);
    chk("t3_cnt0", 64'(count), 64'd0);

    // out-of-order clamp and illegal opcode
    pulse_reset();
    push(32'd20, 2'd0, 32'h300);
    push(32'd15, 2'd1, 32'h310);
    chk("t4_cnt", 64'(count), 64'd2);
    chk("t4_err_order", 64'(err_order), 64'd1);
    chk("t4_no_op_err", 64'(err_opcode), 64'd0);
    push(32'd30, 2'd3, 32'h320);
    chk("t4_cnt_same", 64'(count), 64'd2);
    chk("t4_err_opcode", 64'(err_opcode), 64'd1);
    cur_time = 32'd20;
    ni = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out.op_ready_s) begin
        ea = (ni == 0) ? 32'h300 : 32'h310;
        chk("t4_addr", 64'(out.address), 64'(ea));
        chk("t4_tcpu", 64'(out.time_cpu), 64'd20);
        ni++;
      end
    end
    chk("t4_issued", 64'(ni), 64'd2);

    // async reset while stalled with 4 entries
    queue_full = 1'b1;
    for (int i = 0; i < 4; i++) push(32'd20, 2'd0, 32'h500 + 32'(i));
    chk("t5_cnt4", 64'(count), 64'd4);
    chk("t5_stall", 64'(state), 64'(STALL));
    rst_n = 1'b0;
    #1;
    chk("t5_cnt0", 64'(count), 64'd0);
    chk("t5_valid", 64'(out.op_ready_s), 64'd0);
    chk("t5_idle", 64'(state), 64'(IDLE));
    chk("t5_errs", 64'({err_order, err_opcode}), 64'd0);
    #2 rst_n = 1'b1;
    queue_full = 1'b0;
    step();
    chk("t5_after", 64'(count), 64'd0);

`ifdef TRACE_TIME_SKIP_EN
    pulse_reset();
    cur_time = 32'd3;
    push(32'd100, 2'd0, 32'h400);
    step();
    chk("t6_nv", 64'(next_time_valid), 64'd1);
    chk("t6_nt", 64'(next_time), 64'd100);
    cur_time = 32'd50;
    step();
    chk("t6_nt50", 64'(next_time), 64'd100);
    chk("t6_noissue", 64'(out.op_ready_s), 64'd0);
    cur_time = 32'd99;
    step();
    chk("t6_wait99", 64'(state), 64'(WAIT_TIME));
    cur_time = 32'd100;
    step();
    chk("t6_issue", 64'(out.op_ready_s), 64'd1);
    chk("t6_tcpu", 64'(out.time_cpu), 64'd100);
    chk("t6_nv0", 64'(next_time_valid), 64'd0);
    chk("t6_nt0", 64'(next_time), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
